// File: rtl/data_memory_if.sv
// Store/load bus between the MEM pipeline stage and the data memory.
//   master : MEM stage (drives store request and load address)
//   slave  : data_memory (returns wr_ready and combinational rd_data)
// Signals: wr_valid, wr_adr[31:0], wr_data[WIDTH], wr_ready, rd_adr[31:0], rd_data[WIDTH].
interface data_memory_if #(
  parameter int unsigned WIDTH = 32
);
  logic             wr_valid;
  logic [31:0]      wr_adr;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ready;
  logic [31:0]      rd_adr;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output wr_valid, wr_adr, wr_data, rd_adr,
    input  wr_ready, rd_data
  );

  modport slave (
    input  wr_valid, wr_adr, wr_data, rd_adr,
    output wr_ready, rd_data
  );
endinterface

// File: rtl/data_memory.sv
// Data memory for the MEM stage. Stores are accepted into a small write-buffer FIFO and drained
// into a word-addressed register array one entry per cycle; loads read the array
// combinationally. Out-of-range stores complete the handshake but are dropped and raise a
// sticky oob_err.
// Optional feature macro: DMEM_FORWARD_EN -- loads see the youngest matching buffered store.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : data_memory_if slave (store handshake + load address/data)
//   ram         : full array contents (excludes buffered stores)
//   wbuf_count  : occupied write-buffer entries
//   busy        : write buffer not empty
//   oob_err     : sticky, an out-of-range store was accepted
module data_memory #(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned WBUF_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  data_memory_if.slave                  bus,
  output logic [WIDTH-1:0]              ram [0:DEPTH-1],
  output logic [$clog2(WBUF_DEPTH):0]   wbuf_count,
  output logic                          busy,
  output logic                          oob_err
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(WBUF_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [AW-1:0]    wbuf_adr_q  [0:WBUF_DEPTH-1];
  logic [WIDTH-1:0] wbuf_data_q [0:WBUF_DEPTH-1];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             oob_q;

  logic drain, full, wr_in_range, accept, push, rd_in_range;
  logic [AW-1:0] rd_idx;

  always_comb begin
    drain       = (count_q != '0);
    full        = (count_q == CW'(WBUF_DEPTH));
    // A drain in the same cycle frees the head slot, so a full buffer can still accept.
    bus.wr_ready = !full || drain;
    wr_in_range = (bus.wr_adr < DEPTH);
    accept      = bus.wr_valid && bus.wr_ready;
    push        = accept && wr_in_range;
    rd_in_range = (bus.rd_adr < DEPTH);
    rd_idx      = bus.rd_adr[AW-1:0];
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, drain})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      oob_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (drain) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (accept && !wr_in_range) oob_q <= 1'b1;
    end
  end

  // Buffer payload needs no reset: entries are only read while counted as occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      wbuf_adr_q[wr_ptr_q]  <= bus.wr_adr[AW-1:0];
      wbuf_data_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (drain) begin
      mem_q[wbuf_adr_q[rd_ptr_q]] <= wbuf_data_q[rd_ptr_q];
    end
  end

`ifdef DMEM_FORWARD_EN
  // Scan oldest to youngest so the last match (youngest store) wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx         = '0;
    bus.rd_data = '0;
    if (rd_in_range) begin
      bus.rd_data = mem_q[rd_idx];
      for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
        idx = rd_ptr_q + PW'(i);
        if ((CW'(i) < count_q) && (wbuf_adr_q[idx] == rd_idx)) begin
          bus.rd_data = wbuf_data_q[idx];
        end
      end
    end
  end
`else
  always_comb begin
    bus.rd_data = '0;
    if (rd_in_range) bus.rd_data = mem_q[rd_idx];
  end
`endif

  assign ram        = mem_q;
  assign wbuf_count = count_q;
  assign busy       = drain;
  assign oob_err    = oob_q;
endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: stimulus pushes each accepted in-range store into a queue;
// a monitor pops one entry per drain (busy before the edge) and checks the array word.
module tb_data_memory;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned WBUF  = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [WIDTH-1:0] ram [0:DEPTH-1];
  logic [2:0] wbuf_count;
  logic busy, oob_err;

  data_memory_if #(.WIDTH(WIDTH)) bus ();

  data_memory #(.DEPTH(DEPTH), .WIDTH(WIDTH), .WBUF_DEPTH(WBUF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ram       (ram),
    .wbuf_count(wbuf_count),
    .busy      (busy),
    .oob_err   (oob_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  adr;
    logic [31:0] data;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] model [0:DEPTH-1];
  int          checks = 0;
  int          errors = 0;
  logic        busy_prev = 1'b0;

`ifdef DMEM_FORWARD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int ram_diffs();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== model[i]) n++;
    return n;
  endfunction

  // Monitor: a drain happens on every edge that sees a non-empty buffer.
  always @(negedge clk) busy_prev = busy;

  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      #1;
      if (busy_prev) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("drain_ram", ram[e.adr], e.data);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] adr, input logic [31:0] data);
    @(negedge clk);
    bus.wr_valid = 1'b1;
    bus.wr_adr   = adr;
    bus.wr_data  = data;
    #1 chk("wr_ready", {31'd0, bus.wr_ready}, 32'd1);
    @(posedge clk);
    if (adr < DEPTH) begin
      sb_q.push_back('{adr: adr[4:0], data: data});
      model[adr[4:0]] = data;
    end
  endtask

  task automatic idle_to_negedge();
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    bus.wr_valid = 1'b0;
    bus.wr_adr   = '0;
    bus.wr_data  = '0;
    bus.rd_adr   = 32'd5;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    // Reset state
    chk("rst_ram", ram_diffs(), 0);
    chk("rst_ready", {31'd0, bus.wr_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_oob", {31'd0, oob_err}, 32'd0);
    chk("rst_count", {29'd0, wbuf_count}, 32'd0);
    chk("rst_rd5", bus.rd_data, 32'd0);

    // Single store
    issue(32'd3, 32'hDEADBEEF);
    idle_to_negedge();
    bus.rd_adr = 32'd3;
    #1;
    chk("single_count1", {29'd0, wbuf_count}, 32'd1);
    chk("single_ram_pre", ram[3], 32'd0);
    chk("single_rd", bus.rd_data, Fwd ? 32'hDEADBEEF : 32'd0);
    @(negedge clk);
    chk("single_count0", {29'd0, wbuf_count}, 32'd0);
    chk("single_ram", ram[3], 32'hDEADBEEF);

    // Back-to-back stores, one per cycle; each drain frees its slot so occupancy stays at one
    for (int k = 0; k < 10; k++) begin
      issue(k, k + 32'h100);
      if (k > 0) chk("b2b_count", {29'd0, wbuf_count}, 32'd1);
    end
    idle_to_negedge();
    @(negedge clk);
    chk("b2b_ram", ram_diffs(), 0);

    // Hold wr_valid for many cycles: with a drain on every occupied edge the buffer never
    // reaches WBUF_DEPTH, so wr_ready stays high and push+drain keeps the count steady.
    for (int i = 0; i < 2 * WBUF; i++) issue(32'd20, 32'h200 + i);
    @(negedge clk);
    chk("hold_count", {29'd0, wbuf_count}, 32'd1);
    bus.wr_valid = 1'b0;
    @(negedge clk);
    chk("hold_drained", {29'd0, wbuf_count}, 32'd0);
    chk("hold_ram20", ram[20], 32'h207);

    // Out-of-range store: ram[8] is nonzero so aliasing on the low address bits would show
    issue(32'd40, 32'd1);
    #1;
    chk("oob_flag", {31'd0, oob_err}, 32'd1);
    idle_to_negedge();
    bus.rd_adr = 32'd40;
    #1;
    chk("oob_count", {29'd0, wbuf_count}, 32'd0);
    chk("oob_busy", {31'd0, busy}, 32'd0);
    chk("oob_ram", ram_diffs(), 0);
    chk("oob_rd40", bus.rd_data, 32'd0);

    // Same-address ordering
    issue(32'd7, 32'hA);
    issue(32'd7, 32'hB);
    idle_to_negedge();
    bus.rd_adr = 32'd7;
    #1;
    chk("same_rd", bus.rd_data, Fwd ? 32'hB : 32'hA);
    @(negedge clk);
    chk("same_ram7", ram[7], 32'hB);
    chk("oob_sticky", {31'd0, oob_err}, 32'd1);

    // Reset while a store is still buffered
    issue(32'd9, 32'h55);
    #2;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    sb_q.delete();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    #1;
    chk("mid_count", {29'd0, wbuf_count}, 32'd0);
    chk("mid_busy0", {31'd0, busy}, 32'd0);
    chk("mid_oob", {31'd0, oob_err}, 32'd0);
    chk("mid_ram", ram_diffs(), 0);
    bus.wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_ram9", ram[9], 32'd0);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
